hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REGFILE_ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter TRACK_DEPTH, default 3, number of in-flight write stages tracked (EX, MEM, WB).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, stall-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-007 SHALL have port id_R1_addr  input  REGFILE_ADDR_WIDTH  first source register of decoded instruction.
REQ-008 SHALL have port id_R2_addr  input  REGFILE_ADDR_WIDTH  second source register.
REQ-009 SHALL have port id_imm_sel  input  1  instruction uses immediate; R2 is not a source when high.
REQ-010 SHALL have port id_WR_en  input  1  decoded instruction writes a register.
REQ-011 SHALL have port id_WR_addr  input  REGFILE_ADDR_WIDTH  decoded destination register.
REQ-012 SHALL have port ex_beq, ex_bneq  input  1 each  branch type of the instruction in EX.
REQ-013 SHALL have port ex_zero  input  1  ALU result of the EX instruction equals zero.
REQ-014 SHALL have port mem_busy  input  1  data memory cannot accept an access this cycle.
REQ-015 SHALL have port stall_out  output  1  hold PC and IF/ID register.
REQ-016 SHALL have port bubble_out  output  1  load NOP (WR_en=0, no branch, no mem write) into ID/EX.
REQ-017 SHALL have port flush_out  output  1  clear IF/ID register to NOP.
REQ-018 SHALL have port pc_branch_sel_out  output  1  next PC takes branch target.
REQ-019 SHALL have port stall_cnt_out  output  CNT_WIDTH  saturating count of cycles with stall_out high.

Function
REQ-020 SHALL track, per tracked stage, a valid bit and destination address in a shift register advancing one stage per cycle unless state is HOLD.
REQ-021 SHALL enter stage EX with {id_WR_en & id_valid, id_WR_addr} when the ID instruction issues; with {0,0} when bubble_out or flush_out is high.
REQ-022 SHALL flag a RAW hazard when id_valid and any valid tracked entry matches id_R1_addr, or matches id_R2_addr with id_imm_sel low; address 0 is compared like any other.
REQ-023 SHALL evaluate branch_taken = (ex_beq & ex_zero) | (ex_bneq & ~ex_zero), combinationally from EX inputs.
REQ-024 SHALL implement states RUN, HAZ, FLUSH, HOLD, encoded 2 bits.
REQ-025 SHALL, in RUN: branch_taken -> FLUSH; else mem_busy -> HOLD; else RAW hazard -> HAZ; else stay RUN.
REQ-026 SHALL, in HAZ: assert stall_out and bubble_out; return to RUN when the hazard clears; branch_taken and mem_busy take priority as in RUN.
REQ-027 SHALL, in FLUSH (exactly one cycle): assert flush_out and bubble_out; then RUN.
REQ-028 SHALL assert pc_branch_sel_out combinationally in the cycle branch_taken is high, in any state except HOLD; the same cycle also asserts flush_out and bubble_out.
REQ-029 SHALL, in HOLD: assert stall_out, freeze the tracker, bubble_out low; leave to RUN when mem_busy falls.
REQ-030 SHALL give priority branch_taken > mem_busy > RAW hazard on simultaneous events, except HOLD defers branch_taken until exit.
REQ-031 SHALL increment stall_cnt_out each cycle stall_out is high, holding at all-ones.
REQ-032 SHALL resolve a RAW hazard within TRACK_DEPTH stall cycles of its producer entering EX.

Reset
REQ-033 SHALL, with reset_n low at a clock edge, set state RUN, all tracker entries invalid, stall_cnt_out 0.
REQ-034 SHALL hold stall_out, bubble_out, flush_out, pc_branch_sel_out low while reset_n is low, including mid-HAZ or mid-HOLD.

Structure
REQ-035 SHALL place the state encoding and the NOP control word in the shared processor package.
REQ-036 SHALL implement the tracker as sub-module wr_scoreboard (shift, freeze, insert, compare ports).

Verification
REQ-037 SHALL test: ID R1=3 after producer WR_addr=3 issued previous cycle -> stall_out and bubble_out high 3 cycles, then RUN.
REQ-038 SHALL test: id_imm_sel=1, R2 matches in-flight dest, R1 clear -> no stall.
REQ-039 SHALL test: ex_bneq=1, ex_zero=0 -> pc_branch_sel_out and flush_out same cycle, FLUSH next cycle, then RUN.
REQ-040 SHALL test: mem_busy high 4 cycles during a hazard -> HOLD, tracker frozen, hazard resumes afterwards.
REQ-041 SHALL test: 65540 stall cycles -> stall_cnt_out saturates at 0xFFFF.
REQ-042 SHALL test: reset_n low in HAZ -> next cycle outputs low, RUN, stall_cnt_out 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions for the pipeline hazard controller:
// control FSM encoding and the NOP control word injected as a bubble.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic wr_en;
    logic beq;
    logic bneq;
    logic mem_wr;
  } ctrl_word_t;

  localparam ctrl_word_t NOP_CTRL = '{wr_en: 1'b0, beq: 1'b0, bneq: 1'b0, mem_wr: 1'b0};

endpackage

// File: rtl/hazard_ctrl_wr_scoreboard.sv
// In-flight destination tracker: one {valid, addr} entry per stage (EX first),
// shifting each cycle unless frozen, with source-operand compare against all entries.
module wr_scoreboard #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          freeze,
  input  logic          ins_valid,
  input  logic [AW-1:0] ins_addr,
  input  logic [AW-1:0] cmp_a,
  input  logic [AW-1:0] cmp_b,
  input  logic          cmp_b_en,
  output logic          hit,
  output logic          hit_next
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q,  addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (!freeze) begin
      valid_d[0] = ins_valid;
      addr_d[0]  = ins_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
      end
    end
  end

  // hit_next excludes the oldest stage: only those matches survive the next shift.
  always_comb begin
    hit      = 1'b0;
    hit_next = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ((addr_q[i] == cmp_a) || (cmp_b_en && (addr_q[i] == cmp_b)))) begin
        hit = 1'b1;
        if (i + 1 < DEPTH) hit_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall, branch flush and memory-busy hold
// sequencing for a 5-stage pipeline, plus a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned TRACK_DEPTH        = 3,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          id_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_R1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_R2_addr,
  input  logic                          id_imm_sel,
  input  logic                          id_WR_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_WR_addr,
  input  logic                          ex_beq,
  input  logic                          ex_bneq,
  input  logic                          ex_zero,
  input  logic                          mem_busy,
  output logic                          stall_out,
  output logic                          bubble_out,
  output logic                          flush_out,
  output logic                          pc_branch_sel_out,
  output logic [CNT_WIDTH-1:0]          stall_cnt_out
);

  hz_state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]          stall_cnt_q, stall_cnt_d;
  logic                          branch_taken, take_br, raw, raw_persist;
  logic                          hit, hit_next, freeze, ins_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] ins_addr;

  wr_scoreboard #(
    .AW    (REGFILE_ADDR_WIDTH),
    .DEPTH (TRACK_DEPTH)
  ) u_wr_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .freeze    (freeze),
    .ins_valid (ins_valid),
    .ins_addr  (ins_addr),
    .cmp_a     (id_R1_addr),
    .cmp_b     (id_R2_addr),
    .cmp_b_en  (~id_imm_sel),
    .hit       (hit),
    .hit_next  (hit_next)
  );

  // A held cycle defers a taken branch; once mem_busy drops HOLD behaves like RUN.
  always_comb begin
    branch_taken      = (ex_beq & ex_zero) | (ex_bneq & ~ex_zero);
    take_br           = branch_taken & ~((state_q == ST_HOLD) & mem_busy);
    raw               = id_valid & hit;
    raw_persist       = id_valid & hit_next;
    state_d           = ST_RUN;
    stall_out         = 1'b0;
    bubble_out        = 1'b0;
    flush_out         = 1'b0;
    pc_branch_sel_out = 1'b0;
    freeze            = 1'b0;
    if (state_q == ST_FLUSH) begin
      flush_out         = 1'b1;
      bubble_out        = 1'b1;
      pc_branch_sel_out = branch_taken;
    end else if (take_br) begin
      flush_out         = 1'b1;
      bubble_out        = 1'b1;
      pc_branch_sel_out = 1'b1;
      state_d           = ST_FLUSH;
    end else if (mem_busy) begin
      stall_out = 1'b1;
      freeze    = 1'b1;
      state_d   = ST_HOLD;
    end else if (raw) begin
      stall_out  = 1'b1;
      bubble_out = 1'b1;
      state_d    = raw_persist ? ST_HAZ : ST_RUN;
    end
    if (!reset_n) begin
      stall_out         = 1'b0;
      bubble_out        = 1'b0;
      flush_out         = 1'b0;
      pc_branch_sel_out = 1'b0;
    end
  end

  always_comb begin
    ins_valid = bubble_out ? NOP_CTRL.wr_en : (id_WR_en & id_valid);
    ins_addr  = bubble_out ? '0 : id_WR_addr;
    stall_cnt_d = stall_cnt_q;
    if (stall_out && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes the expected
// {stall,bubble,flush,pc_sel} and counter value; the negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_imm_sel, id_WR_en;
  logic [4:0]  id_R1_addr, id_R2_addr, id_WR_addr;
  logic        ex_beq, ex_bneq, ex_zero, mem_busy;
  logic        stall_out, bubble_out, flush_out, pc_branch_sel_out;
  logic [15:0] stall_cnt_out;

  typedef struct packed {
    logic        chk_cnt;
    logic [15:0] cnt;
    logic [3:0]  outs;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;
  logic        cnt_known = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REGFILE_ADDR_WIDTH (5),
    .TRACK_DEPTH        (3),
    .CNT_WIDTH          (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .id_valid          (id_valid),
    .id_R1_addr        (id_R1_addr),
    .id_R2_addr        (id_R2_addr),
    .id_imm_sel        (id_imm_sel),
    .id_WR_en          (id_WR_en),
    .id_WR_addr        (id_WR_addr),
    .ex_beq            (ex_beq),
    .ex_bneq           (ex_bneq),
    .ex_zero           (ex_zero),
    .mem_busy          (mem_busy),
    .stall_out         (stall_out),
    .bubble_out        (bubble_out),
    .flush_out         (flush_out),
    .pc_branch_sel_out (pc_branch_sel_out),
    .stall_cnt_out     (stall_cnt_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, "_outs"}, {28'd0, stall_out, bubble_out, flush_out, pc_branch_sel_out},
               {28'd0, e.outs});
      if (e.chk_cnt) check_eq({t, "_cnt"}, {16'd0, stall_cnt_out}, {16'd0, e.cnt});
    end
  end

  task automatic idle_inputs();
    id_valid = 1'b0; id_imm_sel = 1'b0; id_WR_en = 1'b0;
    id_R1_addr = 5'd1; id_R2_addr = 5'd2; id_WR_addr = 5'd0;
    ex_beq = 1'b0; ex_bneq = 1'b0; ex_zero = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic imm, input logic we, input logic [4:0] wa);
    id_valid = v; id_R1_addr = r1; id_R2_addr = r2;
    id_imm_sel = imm; id_WR_en = we; id_WR_addr = wa;
  endtask

  // Expected outputs order: {stall, bubble, flush, pc_branch_sel}
  task automatic cyc(input string tag, input logic [3:0] outs);
    exp_t e;
    e.chk_cnt = cnt_known;
    e.cnt     = exp_cnt;
    e.outs    = outs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (!reset_n) begin
      exp_cnt   = '0;
      cnt_known = 1'b1;
    end else if (outs[3] && exp_cnt != 16'hFFFF) begin
      exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 3; i++) cyc("drain", 4'b0000);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    cyc("reset0", 4'b0000);
    cyc("reset1", 4'b0000);
    reset_n = 1'b1;

    // RAW on R1 against producer one cycle ahead: three stall cycles.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd3);
    cyc("raw_prod", 4'b0000);
    set_id(1'b1, 5'd3, 5'd4, 1'b0, 1'b1, 5'd5);
    cyc("raw_s1", 4'b1100);
    cyc("raw_s2", 4'b1100);
    cyc("raw_s3", 4'b1100);
    cyc("raw_go", 4'b0000);
    drain();

    // Immediate form masks R2; register form stalls on stage MEM then WB.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd7);
    cyc("imm_prod", 4'b0000);
    set_id(1'b1, 5'd6, 5'd7, 1'b1, 1'b0, 5'd0);
    cyc("imm_nostall", 4'b0000);
    set_id(1'b1, 5'd6, 5'd7, 1'b0, 1'b0, 5'd0);
    cyc("r2_mem", 4'b1100);
    cyc("r2_wb", 4'b1100);
    cyc("r2_go", 4'b0000);

    // Address 0 compares like any other register; invalid ID never stalls.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd0);
    cyc("z_prod", 4'b0000);
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("z_invalid", 4'b0000);
    set_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 5'd0);
    cyc("z_mem", 4'b1100);
    cyc("z_wb", 4'b1100);
    cyc("z_go", 4'b0000);
    drain();

    // Branch conditions and flush sequencing.
    ex_beq = 1'b1; ex_zero = 1'b0;
    cyc("beq_nz", 4'b0000);
    ex_beq = 1'b0; ex_bneq = 1'b1; ex_zero = 1'b1;
    cyc("bneq_z", 4'b0000);
    ex_zero = 1'b0;
    cyc("bneq_take", 4'b0111);
    ex_bneq = 1'b0;
    cyc("bneq_flush", 4'b0110);
    cyc("bneq_run", 4'b0000);
    ex_beq = 1'b1; ex_zero = 1'b1;
    cyc("beq_take", 4'b0111);
    ex_beq = 1'b0; ex_zero = 1'b0;
    cyc("beq_flush", 4'b0110);

    // Branch outranks a RAW hazard and mem_busy in the same cycle.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd8);
    cyc("brh_prod", 4'b0000);
    set_id(1'b1, 5'd8, 5'd2, 1'b0, 1'b0, 5'd0);
    ex_bneq = 1'b1; mem_busy = 1'b1;
    cyc("brh_take", 4'b0111);
    ex_bneq = 1'b0; mem_busy = 1'b0;
    cyc("brh_flush", 4'b0110);
    id_valid = 1'b0;
    cyc("brh_run", 4'b0000);
    drain();

    // mem_busy during a hazard freezes the tracker; hazard resumes after.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd10);
    cyc("hold_prod", 4'b0000);
    set_id(1'b1, 5'd10, 5'd2, 1'b0, 1'b0, 5'd0);
    cyc("hold_haz", 4'b1100);
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc("hold_busy", 4'b1000);
    mem_busy = 1'b0;
    cyc("hold_resume_wb_frozen", 4'b1100);
    cyc("hold_resume_last", 4'b1100);
    cyc("hold_go", 4'b0000);
    drain();

    // A taken branch is deferred while HOLD is still busy.
    mem_busy = 1'b1;
    cyc("defer_hold", 4'b1000);
    ex_bneq = 1'b1;
    cyc("defer_busy_br", 4'b1000);
    mem_busy = 1'b0;
    cyc("defer_take", 4'b0111);
    ex_bneq = 1'b0;
    cyc("defer_flush", 4'b0110);
    cyc("defer_run", 4'b0000);

    // Counter saturation over a long hold.
    mem_busy = 1'b1;
    for (int i = 0; i < 65540; i++) cyc("sat_busy", 4'b1000);
    mem_busy = 1'b0;
    cyc("sat_end", 4'b0000);
    check_eq("sat_model_ffff", {16'd0, exp_cnt}, 32'h0000_FFFF);

    // Reset asserted mid-HAZ and mid-HOLD.
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd12);
    cyc("rst_prod", 4'b0000);
    set_id(1'b1, 5'd12, 5'd2, 1'b0, 1'b0, 5'd0);
    cyc("rst_haz1", 4'b1100);
    cyc("rst_haz2", 4'b1100);
    reset_n = 1'b0;
    cyc("rst_in_haz", 4'b0000);
    reset_n = 1'b1;
    cyc("rst_after_haz", 4'b0000);
    idle_inputs();
    mem_busy = 1'b1;
    cyc("rst_hold", 4'b1000);
    reset_n = 1'b0;
    cyc("rst_in_hold", 4'b0000);
    reset_n = 1'b1;
    mem_busy = 1'b0;
    cyc("rst_after_hold", 4'b0000);
    cyc("final_idle", 4'b0000);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
